// File: rtl/sdf_bf_stage.sv
// Radix-2 SDF butterfly controller for one FFT stage: steers the external delay lane and
// emits sums (second half-frame) and lane-delayed differences (next first half-frame).
module sdf_bf_stage #(
  parameter  int DELAY_LEN = 8,
  localparam int CW = (DELAY_LEN > 1) ? $clog2(DELAY_LEN) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic signed [15:0] x_in_re,
  input  logic signed [15:0] x_in_im,
  output logic               dl_enable,
  output logic signed [15:0] dl_in_re,
  output logic signed [15:0] dl_in_im,
  input  logic signed [15:0] dl_out_re,
  input  logic signed [15:0] dl_out_im,
  output logic               out_valid,
  output logic signed [15:0] y_re,
  output logic signed [15:0] y_im,
  output logic               out_diff,
  output logic [CW-1:0]      out_idx
);

  localparam int NW = $clog2(2 * DELAY_LEN);

  logic [NW-1:0]      cnt_q, cnt_d;
  logic               primed_q;
  logic               out_valid_q;
  logic signed [15:0] y_re_q, y_im_q;
  logic               out_diff_q;
  logic [CW-1:0]      out_idx_q, idx_d;

  logic               fill, last_fill;
  logic signed [16:0] sum_re, sum_im, dif_re, dif_im;
  logic signed [15:0] s_re, s_im, d_re, d_im;
  logic signed [15:0] cand_re, cand_im;
  logic [NW-1:0]      bf_off;

  assign fill      = cnt_q < NW'(DELAY_LEN);
  assign last_fill = cnt_q == NW'(DELAY_LEN - 1);

  // 17-bit add/sub then floor-halve; the halved result always fits 16 bits.
  assign sum_re = 17'(dl_out_re) + 17'(x_in_re);
  assign sum_im = 17'(dl_out_im) + 17'(x_in_im);
  assign dif_re = 17'(dl_out_re) - 17'(x_in_re);
  assign dif_im = 17'(dl_out_im) - 17'(x_in_im);
  assign s_re   = 16'(sum_re >>> 1);
  assign s_im   = 16'(sum_im >>> 1);
  assign d_re   = 16'(dif_re >>> 1);
  assign d_im   = 16'(dif_im >>> 1);

  assign dl_enable = in_valid;
  assign dl_in_re  = fill ? x_in_re : d_re;
  assign dl_in_im  = fill ? x_in_im : d_im;
  assign cand_re   = fill ? dl_out_re : s_re;
  assign cand_im   = fill ? dl_out_im : s_im;

  assign cnt_d  = (cnt_q == NW'(2 * DELAY_LEN - 1)) ? '0 : cnt_q + 1'b1;
  assign bf_off = cnt_q - NW'(DELAY_LEN);
  assign idx_d  = fill ? CW'(cnt_q) : CW'(bf_off);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      y_re_q      <= '0;
      y_im_q      <= '0;
      out_diff_q  <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      // Until one full half-frame has entered the lane, FILL outputs are stale lane data.
      out_valid_q <= in_valid & (~fill | primed_q);
      if (in_valid) begin
        cnt_q      <= cnt_d;
        if (last_fill) primed_q <= 1'b1;
        y_re_q     <= cand_re;
        y_im_q     <= cand_im;
        out_diff_q <= fill;
        out_idx_q  <= idx_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign y_re      = y_re_q;
  assign y_im      = y_im_q;
  assign out_diff  = out_diff_q;
  assign out_idx   = out_idx_q;

endmodule
